// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending transaction sequencer
package vend_pkg;

  localparam int CREDIT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    DISPENSE,
    CHANGE
  } state_t;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;

  localparam logic [CREDIT_W-1:0] VAL_1  = 6'd1;
  localparam logic [CREDIT_W-1:0] VAL_5  = 6'd5;
  localparam logic [CREDIT_W-1:0] VAL_10 = 6'd10;

  // Value in credit units of a change coin code; unused code maps to 0.
  function automatic logic [CREDIT_W-1:0] coin_code_value(input logic [1:0] code);
    case (code)
      COIN_1:  coin_code_value = VAL_1;
      COIN_5:  coin_code_value = VAL_5;
      COIN_10: coin_code_value = VAL_10;
      default: coin_code_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_selector.sv
// rtl/vend_change_selector.sv - greedy change coin selection from a credit amount
module change_selector
  import vend_pkg::*;
(
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          coin,
  output logic [CREDIT_W-1:0] value
);

  // Largest coin not exceeding credit; value 0 means nothing left to pay.
  always_comb begin
    coin  = COIN_1;
    value = '0;
    if (credit >= VAL_10) begin
      coin  = COIN_10;
      value = VAL_10;
    end else if (credit >= VAL_5) begin
      coin  = COIN_5;
      value = VAL_5;
    end else if (credit >= VAL_1) begin
      coin  = COIN_1;
      value = VAL_1;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending transaction sequencer: credit, select, dispense, change
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_0    = 5,
  parameter int unsigned PRICE_1    = 10,
  parameter int unsigned PRICE_2    = 15,
  parameter int unsigned PRICE_3    = 25,
  parameter int unsigned MAX_CREDIT = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [3:0]          coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                cancel,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic                dispense,
  output logic [1:0]          dispense_item,
  output logic                change_valid,
  output logic [1:0]          change_coin
);

  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                coin_reject_d, sel_reject_d, dispense_d;
  logic [1:0]          dispense_item_d;
  logic                busy_d, change_valid_d;
  logic [1:0]          change_coin_d;
  logic [CREDIT_W-1:0] change_value_d;
  logic [CREDIT_W:0]   coin_sum;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] item);
    case (item)
      2'd0:    price_of = CREDIT_W'(PRICE_0);
      2'd1:    price_of = CREDIT_W'(PRICE_1);
      2'd2:    price_of = CREDIT_W'(PRICE_2);
      default: price_of = CREDIT_W'(PRICE_3);
    endcase
  endfunction

  // Change coin is chosen from the next credit so it is registered alongside it.
  change_selector u_change_selector (
    .credit (credit_d),
    .coin   (change_coin_d),
    .value  (change_value_d)
  );

  // Next-state, next-credit and next-output decode; cancel > select > coin.
  always_comb begin
    state_d         = state_q;
    credit_d        = credit;
    coin_reject_d   = 1'b0;
    sel_reject_d    = 1'b0;
    dispense_d      = 1'b0;
    dispense_item_d = dispense_item;
    coin_sum        = {1'b0, credit} + {3'b000, coin_value};
    case (state_q)
      IDLE, CREDIT: begin
        if (cancel && (credit != '0)) begin
          state_d       = CHANGE;
          coin_reject_d = coin_valid;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (credit >= price_of(sel_item)) begin
            state_d         = DISPENSE;
            dispense_d      = 1'b1;
            dispense_item_d = sel_item;
          end else begin
            sel_reject_d = 1'b1;
          end
        end else if (coin_valid) begin
          if ((coin_value != 4'd0) && (coin_sum <= MAX_SUM)) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_valid;
        credit_d      = credit - price_of(dispense_item);
        state_d       = (credit_d != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_valid && change_ready) begin
          credit_d = credit - coin_code_value(change_coin);
          if (credit_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
    busy_d         = (state_d == DISPENSE) || (state_d == CHANGE);
    change_valid_d = (state_d == CHANGE) && (change_value_d != '0);
  end

  // State and registered outputs; reset drops any pending change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      credit        <= '0;
      busy          <= 1'b0;
      coin_reject   <= 1'b0;
      sel_reject    <= 1'b0;
      dispense      <= 1'b0;
      dispense_item <= 2'd0;
      change_valid  <= 1'b0;
      change_coin   <= 2'd0;
    end else begin
      state_q       <= state_d;
      credit        <= credit_d;
      busy          <= busy_d;
      coin_reject   <= coin_reject_d;
      sel_reject    <= sel_reject_d;
      dispense      <= dispense_d;
      dispense_item <= dispense_item_d;
      change_valid  <= change_valid_d;
      change_coin   <= change_valid_d ? change_coin_d : 2'd0;
    end
  end

endmodule
